stream_rader_permutation: RTL and testbench
===========================================

Name: stream_rader_permutation

Overview:
- Streaming, sequential successor to the combinational merged permutation.
- Accepts frames of SIZE words (SIZE prime) on a valid/ready stream and buffers each frame in a ping-pong memory.
- Emits each frame in identity, Rader-forward or Rader-inverse order, with addresses generated iteratively from a primitive root GEN.
- Sits between the input load path and the prime-length NTT core.

Parameters:
- WIDTH, 32, data word width in bits.
- SIZE, 257, frame length; must be prime.
- GEN, 3, primitive root modulo SIZE.
- GEN_INV, 86, inverse of GEN modulo SIZE (GEN*GEN_INV mod SIZE = 1).
- AW, $clog2(SIZE), address width.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- in_data  in  WIDTH  input word
- in_valid  in  1  input word valid
- in_last  in  1  marks the SIZE-th word of a frame
- in_ready  out  1  block can accept in_data
- perm_select  in  2  frame mode; sampled with the first word of each frame
- out_data  out  WIDTH  permuted output word
- out_valid  out  1  out_data valid
- out_last  out  1  marks the final word of an output frame
- out_ready  in  1  downstream accepts out_data
- frame_err  out  1  sticky flag: in_last position mismatch

Behaviour:
- Reset (rst_n low at a clk edge): all banks marked empty; both counters 0; in_ready=0 during reset and 1 in the first cycle after; out_valid=0, out_last=0, out_data=0, frame_err=0. Reset mid-frame discards all buffered and partial frames.
- Input transfer occurs on in_valid&&in_ready.
  - Word n (0..SIZE-1) is written to address n of the current fill bank.
  - perm_select is latched per bank at n=0.
  - On n=SIZE-1 the fill bank is marked full and the fill pointer toggles.
- in_ready=0 when the next fill bank is still full, i.e. both banks are full or draining.
- in_last:
  - in_last=1 with n≠SIZE-1, or in_last=0 with n=SIZE-1, sets frame_err.
  - The frame still closes on the count only; in_last never truncates it.
- Drain FSM states: IDLE, PRIME, STREAM.
  - IDLE→PRIME when the drain bank is full.
  - PRIME issues the first synchronous read; out_valid rises 2 cycles after the bank becomes full (read latency 1 plus output register).
  - STREAM advances one word per out_valid&&out_ready.
  - out_data and out_valid are held stable while out_ready=0; the read pipeline stalls with no word loss or duplication.
- Read address sequence, output index k=0..SIZE-1:
  - mode 0 / mode 3: addr=k (identity; mode 3 reserved and treated as identity).
  - mode 1 (forward): k=0→addr 0; k≥1→addr=GEN^(k-1) mod SIZE. Iterate with a=(a*GEN) mod SIZE, seeded at 1; the product is 2*AW bits wide before the reduction.
  - mode 2 (inverse): same, using GEN_INV.
- out_last=1 on k=SIZE-1. After that transfer the bank is marked empty and the drain pointer toggles.
  - If the other bank is already full: go to PRIME and re-prime, so there is one bubble cycle between frames.
  - Otherwise go to IDLE.
- A bank that is freed and filled in the same cycle: free takes effect first, so in_ready may stay 1 continuously for back-to-back frames.
- Simultaneous input and output activity on opposite banks is fully independent.

Optional Feature:
- Macro PERM_FRAME_CNT_EN.
- Defined: adds output port frames_done [31:0]. It resets to 0, increments on each out_last transfer and wraps at 2^32.
- Undefined: the port and the counter are absent; behaviour is otherwise identical.

Test Plan:
- Identity: perm_select=0, in_data=i for i=0..256, out_ready=1 → out 0,1,2,…,256; out_last only with 256; first out_valid 2 cycles after in_last accepted.
- Forward Rader: perm_select=1, in_data=i → out 0,1,3,9,27,81,243,215,…; final word (k=256) =86 with out_last=1.
- Inverse Rader: perm_select=2, in_data=i → out 0,1,86,200,…; final word =3.
- Back-to-back plus backpressure:
  - Stimulus: 3 frames with modes 1,2,0 streamed continuously; out_ready toggling 1,0,0,1 pattern.
  - Required: all 771 outputs match the expected order, none dropped or duplicated; in_ready=0 only while both banks are occupied.
- in_last error: in_last=1 on word 100 of a 257-word frame → frame_err=1 from the next cycle and stays set; the frame still outputs 257 words.
- Reset mid-operation: assert rst_n=0 for 1 cycle at word 150 of input while a prior frame is draining at k=40.
  - Required: out_valid=0 and frame_err=0 after reset; a fresh identity frame then outputs 0..256 correctly.
  - Under PERM_FRAME_CNT_EN: frames_done=0 after reset and =1 after that frame.

Source files
------------

// File: rtl/stream_rader_permutation.sv
// Streaming ping-pong frame buffer that replays each prime-length frame in identity,
// Rader-forward or Rader-inverse order. Define PERM_FRAME_CNT_EN to add the frames_done counter.
module stream_rader_permutation #(
    parameter int WIDTH   = 32,
    parameter int SIZE    = 257,
    parameter int GEN     = 3,
    parameter int GEN_INV = 86,
    parameter int AW      = $clog2(SIZE)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    input  logic [1:0]       perm_select,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    output logic             out_last,
    input  logic             out_ready,
    output logic             frame_err
`ifdef PERM_FRAME_CNT_EN
    ,
    output logic [31:0]      frames_done
`endif
);
    localparam logic [AW-1:0]   LAST_IDX  = AW'(SIZE - 1);
    localparam logic [2*AW-1:0] SIZE_P    = (2*AW)'(SIZE);
    localparam logic [AW-1:0]   GEN_A     = AW'(GEN);
    localparam logic [AW-1:0]   GEN_INV_A = AW'(GEN_INV);

    typedef enum logic [1:0] {IDLE, PRIME, STREAM} drain_state_t;

    function automatic logic [AW-1:0] mulmod(input logic [AW-1:0] a, input logic [AW-1:0] g);
        logic [2*AW-1:0] prod;
        prod = {{AW{1'b0}}, a} * {{AW{1'b0}}, g};
        return AW'(prod % SIZE_P);
    endfunction

    logic [WIDTH-1:0] mem0 [SIZE];
    logic [WIDTH-1:0] mem1 [SIZE];

    logic          fill_ptr;
    logic [AW-1:0] fill_cnt;
    logic [1:0]    bank_full;
    logic [1:0]    bank_full_nxt;
    logic [1:0]    bank_mode [2];
    logic          in_fire;
    logic          fill_done;

    drain_state_t     state;
    logic             drain_ptr;
    logic [AW-1:0]    iss_k;
    logic [AW-1:0]    pw;
    logic             iss_done;
    logic             vld_p1;
    logic             last_p1;
    logic [WIDTH-1:0] data_p1;
    logic             adv_out;
    logic             adv_p1;
    logic             issue;
    logic             out_xfer;
    logic             drain_free;
    logic [AW-1:0]    rd_addr;
    logic [1:0]       drain_mode;
    logic [AW-1:0]    gen_sel;

    always_comb begin
        out_xfer   = out_valid && out_ready;
        drain_free = out_xfer && out_last;
        // A bank released this cycle may be refilled immediately, keeping back-to-back input gapless.
        in_ready   = rst_n && (!bank_full[fill_ptr] || (drain_free && (drain_ptr == fill_ptr)));
        in_fire    = in_valid && in_ready;
        fill_done  = in_fire && (fill_cnt == LAST_IDX);

        bank_full_nxt = bank_full;
        if (drain_free) bank_full_nxt[drain_ptr] = 1'b0;
        if (fill_done)  bank_full_nxt[fill_ptr]  = 1'b1;

        adv_out = !out_valid || out_ready;
        adv_p1  = !vld_p1 || adv_out;
        issue   = adv_p1 && ((state == PRIME) || ((state == STREAM) && !iss_done));

        drain_mode = bank_mode[drain_ptr];
        gen_sel    = (drain_mode == 2'd2) ? GEN_INV_A : GEN_A;
        if (((drain_mode == 2'd1) || (drain_mode == 2'd2)) && (iss_k != '0))
            rd_addr = pw;
        else
            rd_addr = iss_k;
    end

    // Fill side: word counter, per-bank mode latch, framing check.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fill_ptr     <= 1'b0;
            fill_cnt     <= '0;
            bank_full    <= '0;
            bank_mode[0] <= '0;
            bank_mode[1] <= '0;
            frame_err    <= 1'b0;
        end else begin
            bank_full <= bank_full_nxt;
            if (in_fire) begin
                if (fill_cnt == '0) bank_mode[fill_ptr] <= perm_select;
                if (in_last != (fill_cnt == LAST_IDX)) frame_err <= 1'b1;
                if (fill_done) begin
                    fill_cnt <= '0;
                    fill_ptr <= !fill_ptr;
                end else begin
                    fill_cnt <= fill_cnt + AW'(1);
                end
            end
        end
    end

    // Stage p0 -> p1: bank write and synchronous read.
    always_ff @(posedge clk) begin
        if (in_fire) begin
            if (fill_ptr) mem1[fill_cnt] <= in_data;
            else          mem0[fill_cnt] <= in_data;
        end
        if (issue) data_p1 <= drain_ptr ? mem1[rd_addr] : mem0[rd_addr];
    end

    // Drain FSM with p1 -> output register stage; both stall together under backpressure.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            drain_ptr <= 1'b0;
            iss_k     <= '0;
            pw        <= AW'(1);
            iss_done  <= 1'b0;
            vld_p1    <= 1'b0;
            last_p1   <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
        end else begin
            if (adv_p1) begin
                vld_p1  <= issue;
                last_p1 <= issue && (iss_k == LAST_IDX);
            end
            if (adv_out) begin
                out_valid <= vld_p1;
                out_last  <= vld_p1 && last_p1;
                if (vld_p1) out_data <= data_p1;
            end
            if (issue) begin
                iss_k <= iss_k + AW'(1);
                if (iss_k != '0)       pw       <= mulmod(pw, gen_sel);
                if (iss_k == LAST_IDX) iss_done <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (bank_full_nxt[drain_ptr]) begin
                        state    <= PRIME;
                        iss_k    <= '0;
                        pw       <= AW'(1);
                        iss_done <= 1'b0;
                    end
                end
                PRIME: begin
                    if (issue) state <= STREAM;
                end
                STREAM: begin
                    if (drain_free) begin
                        drain_ptr <= !drain_ptr;
                        iss_k     <= '0;
                        pw        <= AW'(1);
                        iss_done  <= 1'b0;
                        state     <= bank_full_nxt[!drain_ptr] ? PRIME : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef PERM_FRAME_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n)          frames_done <= '0;
        else if (drain_free) frames_done <= frames_done + 32'd1;
    end
`endif

endmodule

// File: tb/tb_stream_rader_permutation.sv
// Self-checking bench for stream_rader_permutation: reference-order scoreboard, vector table,
// framing-error and mid-operation reset sequences.
module tb_stream_rader_permutation;
    localparam int WIDTH   = 32;
    localparam int SIZE    = 257;
    localparam int GEN     = 3;
    localparam int GEN_INV = 86;
    localparam int CAPN    = 4 * SIZE;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_last;
    logic             in_ready;
    logic [1:0]       perm_select;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_last;
    logic             out_ready;
    logic             frame_err;
`ifdef PERM_FRAME_CNT_EN
    logic [31:0]      frames_done;
`endif

    always #5 clk = ~clk;

    stream_rader_permutation #(
        .WIDTH(WIDTH), .SIZE(SIZE), .GEN(GEN), .GEN_INV(GEN_INV)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
        .perm_select(perm_select),
        .out_data(out_data), .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready),
        .frame_err(frame_err)
`ifdef PERM_FRAME_CNT_EN
        , .frames_done(frames_done)
`endif
    );

    typedef struct {
        logic [WIDTH-1:0] data;
        logic             last;
        logic             eof;
        logic             err;
        logic [1:0]       mode;
    } stim_t;
    typedef struct {
        logic [WIDTH-1:0] data;
        logic             last;
    } exp_t;
    typedef struct {
        int               frame;
        int               k;
        logic [WIDTH-1:0] value;
    } vec_t;

    stim_t            stim_q[$];
    exp_t             exp_q[$];
    logic [WIDTH-1:0] cap [CAPN];
    int               cap_n;
    int               n_tests = 0;
    int               n_fail  = 0;
    int               cyc     = 0;
    int               in_acc;
    int               full_cnt;
    int               rdy_pat;
    int               last_in_cyc;
    int               first_out_cyc;
    bit               err_pend;
    vec_t             vt [14];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Reference order: mode 1/2 output k>0 reads element g^(k-1) mod SIZE.
    function automatic int ref_index(input int mode, input int k);
        int g;
        int r;
        if ((mode != 1) && (mode != 2)) return k;
        if (k == 0) return 0;
        g = (mode == 1) ? GEN : GEN_INV;
        r = 1;
        for (int e = 1; e < k; e++) r = (r * g) % SIZE;
        return r;
    endfunction

    task automatic add_frame(input int mode, input bit rnd, input int err_word);
        logic [WIDTH-1:0] d [SIZE];
        stim_t s;
        exp_t  e;
        for (int i = 0; i < SIZE; i++) d[i] = rnd ? WIDTH'($urandom) : WIDTH'(i);
        for (int i = 0; i < SIZE; i++) begin
            s.data = d[i];
            s.eof  = (i == SIZE - 1);
            s.err  = (i == err_word);
            s.last = s.eof || s.err;
            s.mode = 2'(mode);
            stim_q.push_back(s);
        end
        for (int k = 0; k < SIZE; k++) begin
            e.data = d[ref_index(mode, k)];
            e.last = (k == SIZE - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic apply_inputs();
        if (stim_q.size() > 0) begin
            in_valid    = 1'b1;
            in_data     = stim_q[0].data;
            in_last     = stim_q[0].last;
            perm_select = stim_q[0].mode;
        end else begin
            in_valid    = 1'b0;
            in_data     = '0;
            in_last     = 1'b0;
            perm_select = 2'd0;
        end
        case (rdy_pat)
            0:       out_ready = 1'b1;
            1:       out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
            default: out_ready = 1'b0;
        endcase
    endtask

    task automatic tick();
        bit   in_fire;
        bit   out_fire;
        bit   rdy_exp;
        exp_t e;
        @(negedge clk);
        in_fire  = in_valid && in_ready;
        out_fire = out_valid && out_ready;
        rdy_exp  = (full_cnt < 2) || (out_fire && (exp_q.size() > 0) && exp_q[0].last);
        check("in_ready", in_ready, rdy_exp);
        if (err_pend) begin
            check("frame_err_set", frame_err, 1);
            err_pend = 0;
        end
        if (out_valid && (first_out_cyc < 0)) first_out_cyc = cyc;
        if (out_fire) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL extra_word: got 0x%0h, expected no output", out_data);
            end else begin
                e = exp_q.pop_front();
                check("out_data", out_data, e.data);
                check("out_last", out_last, e.last);
                if (e.last) full_cnt--;
            end
            if (cap_n < CAPN) begin
                cap[cap_n] = out_data;
                cap_n++;
            end
        end
        if (in_fire) begin
            in_acc++;
            if (stim_q[0].eof) full_cnt++;
            if (stim_q[0].err) err_pend = 1;
            if (stim_q[0].eof && (last_in_cyc < 0)) last_in_cyc = cyc;
        end
        @(posedge clk);
        cyc++;
        #1;
        if (in_fire) void'(stim_q.pop_front());
        apply_inputs();
    endtask

    task automatic run_drain(input string name, input int max_cyc);
        int n;
        n = 0;
        apply_inputs();
        while (((stim_q.size() > 0) || (exp_q.size() > 0)) && (n < max_cyc)) begin
            tick();
            n++;
        end
        check({name, "_remaining"}, stim_q.size() + exp_q.size(), 0);
        repeat (4) tick();
    endtask

    initial begin
        vt[0]  = '{0, 0,   0};
        vt[1]  = '{0, 100, 100};
        vt[2]  = '{0, 256, 256};
        vt[3]  = '{1, 0,   0};
        vt[4]  = '{1, 1,   1};
        vt[5]  = '{1, 2,   3};
        vt[6]  = '{1, 3,   9};
        vt[7]  = '{1, 7,   215};
        vt[8]  = '{1, 256, 86};
        vt[9]  = '{2, 2,   86};
        vt[10] = '{2, 3,   200};
        vt[11] = '{2, 256, 3};
        vt[12] = '{3, 5,   5};
        vt[13] = '{3, 256, 256};

        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
        perm_select = 2'd0; out_ready = 1'b1; rdy_pat = 0;
        full_cnt = 0; in_acc = 0; cap_n = 0; err_pend = 0;
        last_in_cyc = -1; first_out_cyc = -1;

        // Power-on reset.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_in_ready_low", in_ready, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("reset_in_ready_high", in_ready, 1);
        check("reset_out_valid", out_valid, 0);
        check("reset_out_last", out_last, 0);
        check("reset_out_data", out_data, 0);
        check("reset_frame_err", frame_err, 0);
`ifdef PERM_FRAME_CNT_EN
        check("reset_frames_done", frames_done, 0);
`endif
        @(posedge clk);
        #1;

        // Identity, forward, inverse back-to-back with data = index, then reserved mode 3.
        add_frame(0, 0, -1);
        add_frame(1, 0, -1);
        add_frame(2, 0, -1);
        run_drain("modes_012", 3000);
        check("first_out_latency", first_out_cyc - last_in_cyc, 3);
        add_frame(3, 0, -1);
        run_drain("mode_3", 1000);
        check("capture_count", cap_n, CAPN);
        for (int i = 0; i < 14; i++)
            check($sformatf("vec_f%0d_k%0d", vt[i].frame, vt[i].k),
                  cap[vt[i].frame * SIZE + vt[i].k], vt[i].value);

        // Random data, continuous input, out_ready pattern 1,0,0,1.
        rdy_pat = 1;
        add_frame(1, 1, -1);
        add_frame(2, 1, -1);
        add_frame(0, 1, -1);
        run_drain("backpressure", 6000);

        // Early in_last on word 100: sticky error, frame length unchanged.
        rdy_pat = 0;
        check("frame_err_before", frame_err, 0);
        add_frame(1, 1, 100);
        run_drain("early_last", 1000);
        check("frame_err_sticky", frame_err, 1);
`ifdef PERM_FRAME_CNT_EN
        check("frames_done_8", frames_done, 8);
`endif

        // Reset while frame A drains and frame B is at word 150.
        rdy_pat = 2;
        in_acc = 0;
        add_frame(0, 0, -1);
        add_frame(0, 0, -1);
        apply_inputs();
        for (int n = 0; (n < 2000) && (in_acc < SIZE + 110); n++) tick();
        rdy_pat = 0;
        for (int n = 0; (n < 2000) && (in_acc < SIZE + 151); n++) tick();
        check("pre_reset_words_in", in_acc, SIZE + 151);
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_last = 1'b0;
        stim_q.delete();
        exp_q.delete();
        full_cnt = 0;
        err_pend = 0;
        @(negedge clk);
        check("midrst_in_ready_low", in_ready, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_frame_err", frame_err, 0);
        check("midrst_in_ready", in_ready, 1);
`ifdef PERM_FRAME_CNT_EN
        check("midrst_frames_done", frames_done, 0);
`endif
        @(posedge clk);
        #1;
        add_frame(0, 0, -1);
        run_drain("post_reset", 1000);
`ifdef PERM_FRAME_CNT_EN
        check("frames_done_1", frames_done, 1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
